// File: rtl/hera_isa_pkg.sv
// HERA ISA constants, decode-bundle type and squash FSM states shared by the decode stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hera_isa_pkg;

  // One-hot class bit positions inside op_class
  localparam int CLS_SET   = 0;
  localparam int CLS_AL    = 1;
  localparam int CLS_SHIFT = 2;
  localparam int CLS_MEM   = 3;
  localparam int CLS_BR    = 4;
  localparam int CLS_SP_BR = 5;
  localparam int CLS_CALL  = 6;
  localparam int CLS_SWI   = 7;

  // Opcode constants
  localparam logic [11:0] OP_SWI     = 12'h30F;   // q[15:4]; carved out of the DEC space
  localparam logic [7:0]  OP_SP_BR   = 8'h01;     // q[15:8]
  localparam logic [3:0]  SP_BR_COND = 4'h1;      // branch condition reserved for special branches
  localparam logic [15:0] OP_RETURN  = 16'h0110;
  localparam logic [15:0] OP_RTI     = 16'h0120;

  // Top-bit match patterns
  localparam logic [2:0] de_set   = 3'b111;
  localparam logic [2:0] de_al0   = 3'b100;
  localparam logic [2:0] de_al1   = 3'b101;
  localparam logic [2:0] de_al2   = 3'b110;
  localparam logic [3:0] de_shift = 4'b0011;
  localparam logic [1:0] de_mem   = 2'b01;
  localparam logic [3:0] de_call  = 4'b0010;
  localparam logic [2:0] de_br    = 3'b000;
  localparam logic [3:0] de_mul   = 4'b1100;

  // AL codes are q[14:12]
  localparam logic [2:0] op_al_code_and = 3'd0;
  localparam logic [2:0] op_al_code_or  = 3'd1;
  localparam logic [2:0] op_al_code_add = 3'd2;
  localparam logic [2:0] op_al_code_sub = 3'd3;
  localparam logic [2:0] op_al_code_mul = 3'd4;
  localparam logic [2:0] op_al_code_xor = 3'd5;

  // Shift-family codes; 0..5 come straight from q[6:4]
  localparam logic [3:0] op_shift_code_lsl   = 4'd0;
  localparam logic [3:0] op_shift_code_asr   = 4'd5;
  localparam logic [3:0] op_shift_code_setf  = 4'd6;
  localparam logic [3:0] op_shift_code_clrf  = 4'd7;
  localparam logic [3:0] op_shift_code_savef = 4'd8;
  localparam logic [3:0] op_shift_code_rstrf = 4'd9;
  localparam logic [3:0] op_shift_code_inc   = 4'd10;
  localparam logic [3:0] op_shift_code_dec   = 4'd11;

  // Branch code is {relative, cond} = q[12:8]
  localparam logic [4:0] op_br_code_br     = 5'h00;
  localparam logic [4:0] op_br_code_rel    = 5'h10;

  // Special-branch code is q[5:4]
  localparam logic [1:0] op_special_br_code_jmp    = 2'd0;
  localparam logic [1:0] op_special_br_code_return = 2'd1;
  localparam logic [1:0] op_special_br_code_rti    = 2'd2;
  localparam logic [1:0] op_special_br_code_wait   = 2'd3;

  typedef struct packed {
    logic [7:0] op_class;
    logic [4:0] op_code;
    logic [3:0] rsa;
    logic [3:0] rsb;
    logic [3:0] rd;
    logic [7:0] v_data;
    logic       load_en;
    logic       mul_en;
    logic       illegal;
  } dec_bundle_t;

  localparam int DEC_BUNDLE_W = $bits(dec_bundle_t);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_SQUASH = 1'b1} sq_state_e;

endpackage

// File: rtl/hera_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready valid-ready pairs.
// slave = decode stage side, master = fetch/execute side.
interface hera_decode_stage_if #(
  parameter int INSTR_W = 16,
  parameter int RA_W    = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         op_class;
  logic [4:0]         op_code;
  logic [RA_W-1:0]    rsa;
  logic [RA_W-1:0]    rsb;
  logic [RA_W-1:0]    rd;
  logic [7:0]         v_data;
  logic               load_en;
  logic               mul_en;
  logic               hold_pc;
  logic               illegal;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, op_class, op_code, rsa, rsb, rd, v_data,
           load_en, mul_en, hold_pc, illegal
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, op_class, op_code, rsa, rsb, rd, v_data,
           load_en, mul_en, hold_pc, illegal
  );
endinterface

// File: rtl/hera_decode_comb.sv
// Purely combinational HERA word -> decode bundle.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: instr_i word in; bundle_o decoded fields; ret_o high for RETURN/RTI.
module hera_decode_comb
  import hera_isa_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_bundle_t bundle_o,
  output logic        ret_o
);
  logic [15:0] q;
  logic is_set, is_al, is_shift, is_mem, is_call, is_swi, is_sp_br, is_br;
  logic sh_incdec, sh_flag, sh_rstrf;
  logic [3:0] sh_code;

  assign q         = instr_i;
  assign is_set    = (q[15:13] == de_set);
  assign is_al     = (q[15:13] inside {de_al0, de_al1, de_al2});
  assign is_swi    = (q[15:4] == OP_SWI);
  assign is_shift  = (q[15:12] == de_shift) && !is_swi;
  assign is_mem    = (q[15:14] == de_mem);
  assign is_call   = (q[15:12] == de_call);
  assign is_sp_br  = (q[15:8] == OP_SP_BR);
  // All-zero word is the NOP and must not decode as a branch
  assign is_br     = (q[15:13] == de_br) && (q[11:8] != SP_BR_COND) && (q != 16'h0000);
  assign sh_incdec = is_shift && q[7];
  assign sh_flag   = is_shift && (q[7:4] == 4'b0110);
  assign sh_rstrf  = is_shift && (q[7:4] == 4'b0111) && q[3];
  assign ret_o     = (q == OP_RETURN) || (q == OP_RTI);

  always_comb begin
    sh_code = {1'b0, q[6:4]};
    if (q[7])                    sh_code = q[6] ? op_shift_code_dec : op_shift_code_inc;
    else if (q[6:4] == 3'b110)   sh_code = q[11] ? op_shift_code_clrf : op_shift_code_setf;
    else if (q[6:4] == 3'b111)   sh_code = q[3] ? op_shift_code_rstrf : op_shift_code_savef;
  end

  always_comb begin
    bundle_o = '0;
    bundle_o.op_class[CLS_SET]   = is_set;
    bundle_o.op_class[CLS_AL]    = is_al;
    bundle_o.op_class[CLS_SHIFT] = is_shift;
    bundle_o.op_class[CLS_MEM]   = is_mem;
    bundle_o.op_class[CLS_BR]    = is_br;
    bundle_o.op_class[CLS_SP_BR] = is_sp_br;
    bundle_o.op_class[CLS_CALL]  = is_call;
    bundle_o.op_class[CLS_SWI]   = is_swi;

    if (is_al)          bundle_o.op_code = {2'b0, q[14:12]};
    else if (is_shift)  bundle_o.op_code = {1'b0, sh_code};
    else if (is_br)     bundle_o.op_code = q[12:8];
    else if (is_sp_br)  bundle_o.op_code = {3'b0, q[5:4]};
    else if (is_set)    bundle_o.op_code = {4'b0, q[12]};
    else if (is_mem)    bundle_o.op_code = {4'b0, q[13]};

    if (is_set || sh_incdec || sh_rstrf) bundle_o.rsa = q[11:8];
    else if (is_al)                      bundle_o.rsa = q[7:4];
    else                                 bundle_o.rsa = q[3:0];
    bundle_o.rsb = q[3:0];
    bundle_o.rd  = (sh_rstrf || is_br || is_sp_br) ? 4'h0 : q[11:8];

    if (sh_flag)        bundle_o.v_data = {3'b0, q[8], q[3:0]};
    else if (sh_incdec) bundle_o.v_data = {2'b0, q[5:0]};
    else if (is_mem)    bundle_o.v_data = {3'b0, q[12], q[7:4]};
    else if (is_call)   bundle_o.v_data = q[11:4];
    else if (is_swi)    bundle_o.v_data = {4'b0, q[3:0]};
    else                bundle_o.v_data = q[7:0];

    bundle_o.load_en = is_mem && q[13];
    bundle_o.mul_en  = (q[15:12] == de_mul);
    bundle_o.illegal = (bundle_o.op_class == 8'h00) && (q != 16'h0000);
  end
endmodule

// File: rtl/hera_decode_stage.sv
// Registered HERA decode stage with one-entry skid buffer, RETURN/RTI squash window and flush.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: output holds while !out_ready; one more word parks in the skid, then in_ready drops.
// Ports: clk, rst (sync, active-high); bus = fetch-side in_* / flush and execute-side out_* bundle.
module hera_decode_stage
  import hera_isa_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int RA_W     = 4,
  parameter int SQUASH_N = 1
)(
  input  logic                 clk,
  input  logic                 rst,
  hera_decode_stage_if.slave   bus
);
  localparam logic [2:0] SQ_INIT = 3'(SQUASH_N);

  sq_state_e    st_q, st_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         out_vld_q, out_bubble_q;
  dec_bundle_t  out_q;
  logic         skid_vld_q, skid_kill_q;
  logic [15:0]  skid_instr_q;

  logic [INSTR_W-1:0] in_word;
  logic         in_ready, accept, out_free, out_load;
  logic         kill_now, src_kill, dec_ret;
  logic [15:0]  src_instr;
  dec_bundle_t  dec, dec_k;

  assign in_word  = bus.in_instr;
  assign in_ready = !skid_vld_q;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign out_free = !out_vld_q || bus.out_ready;
  assign out_load = out_free && (skid_vld_q || accept);

  // Skid has priority so FIFO order holds; its kill flag was fixed when it was accepted
  assign src_instr = skid_vld_q ? skid_instr_q : in_word[15:0];
  assign src_kill  = skid_vld_q ? skid_kill_q : kill_now;

  hera_decode_comb u_dec (
    .instr_i  (src_instr),
    .bundle_o (dec),
    .ret_o    (dec_ret)
  );

  always_comb begin
    dec_k = dec;
    if (src_kill) begin
      dec_k.op_class = '0;
      dec_k.load_en  = 1'b0;
      dec_k.mul_en   = 1'b0;
      dec_k.illegal  = 1'b0;
      dec_k.rd       = '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_RUN;
      cnt_q <= 3'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // FSM: next state. A killed RETURN never arms, so back-to-back RETURNs do not extend the window.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_RUN: begin
        if (out_load && !src_kill && dec_ret && (SQUASH_N != 0)) begin
          st_d  = ST_SQUASH;
          cnt_d = SQ_INIT;
        end
      end
      ST_SQUASH: begin
        if (accept) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) st_d = ST_RUN;
        end
      end
      default: st_d = ST_RUN;
    endcase
    if (bus.flush) begin
      st_d  = ST_RUN;
      cnt_d = 3'd0;
    end
  end

  // FSM: outputs. hold_pc also covers the last bubble still sitting in the output register.
  always_comb begin
    kill_now    = (st_q == ST_SQUASH);
    bus.hold_pc = kill_now || (out_vld_q && out_bubble_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q    <= 1'b0;
      out_bubble_q <= 1'b0;
      out_q        <= '0;
      skid_vld_q   <= 1'b0;
      skid_kill_q  <= 1'b0;
      skid_instr_q <= '0;
    end else if (bus.flush) begin
      out_vld_q    <= 1'b0;
      out_bubble_q <= 1'b0;
      skid_vld_q   <= 1'b0;
    end else begin
      if (out_load) begin
        out_q        <= dec_k;
        out_bubble_q <= src_kill;
        out_vld_q    <= 1'b1;
      end else if (out_free) begin
        out_vld_q    <= 1'b0;
      end
      if (skid_vld_q) begin
        if (out_free) skid_vld_q <= 1'b0;
      end else if (accept && !out_free) begin
        skid_vld_q   <= 1'b1;
        skid_instr_q <= in_word[15:0];
        skid_kill_q  <= kill_now;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_vld_q;
  assign bus.op_class  = out_q.op_class;
  assign bus.op_code   = out_q.op_code;
  assign bus.rsa       = RA_W'(out_q.rsa);
  assign bus.rsb       = RA_W'(out_q.rsb);
  assign bus.rd        = RA_W'(out_q.rd);
  assign bus.v_data    = out_q.v_data;
  assign bus.load_en   = out_vld_q && out_q.load_en;
  assign bus.mul_en    = out_vld_q && out_q.mul_en;
  assign bus.illegal   = out_vld_q && out_q.illegal;
endmodule

// File: tb/tb_hera_decode_stage.sv
module tb_hera_decode_stage;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hera_decode_stage_if #(.INSTR_W(16), .RA_W(4)) bus ();
  hera_decode_stage_if #(.INSTR_W(16), .RA_W(4)) bus0 ();

  hera_decode_stage #(.INSTR_W(16), .RA_W(4), .SQUASH_N(2)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  hera_decode_stage #(.INSTR_W(16), .RA_W(4), .SQUASH_N(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_instr  = bus.in_instr;
  assign bus0.flush     = bus.flush;
  assign bus0.out_ready = bus.out_ready;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  cls;
    logic [4:0]  code;
    logic [3:0]  rd, rsa, rsb;
    logic [7:0]  v;
    logic        ld, mul, ill;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic vld, input logic [15:0] w);
    bus.in_valid = vld;
    bus.in_instr = w;
  endtask

  initial begin
    vecs[0]  = '{16'hA123, 8'h02, 5'h02, 4'h1, 4'h2, 4'h3, 8'h23, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hE1FF, 8'h01, 5'h00, 4'h1, 4'h1, 4'hF, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'hC456, 8'h02, 5'h04, 4'h4, 4'h5, 4'h6, 8'h56, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'h5A37, 8'h08, 5'h00, 4'hA, 4'h7, 4'h7, 8'h13, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h6A37, 8'h08, 5'h01, 4'hA, 4'h7, 4'h7, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{16'h2AB0, 8'h40, 5'h00, 4'hA, 4'h0, 4'h0, 8'hAB, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h3285, 8'h04, 5'h0A, 4'h2, 4'h2, 4'h5, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'h30F5, 8'h80, 5'h00, 4'h0, 4'h5, 4'h5, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h1100, 8'h00, 5'h00, 4'h1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{16'h0000, 8'h00, 5'h00, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h1A42, 8'h10, 5'h1A, 4'h0, 4'h2, 4'h2, 8'h42, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h3A6B, 8'h04, 5'h07, 4'hA, 4'hB, 4'hB, 8'h0B, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h3978, 8'h04, 5'h09, 4'h0, 4'h9, 4'h8, 8'h78, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    put(1'b0, 16'h0000);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {15'b0, bus.out_valid}, 16'h0);
    chk("rst_in_ready",  {15'b0, bus.in_ready}, 16'h1);
    chk("rst_hold_pc",   {15'b0, bus.hold_pc}, 16'h0);
    chk("rst_op_class",  {8'b0, bus.op_class}, 16'h0);
    chk("rst_rd",        {12'b0, bus.rd}, 16'h0);
    chk("rst_v_data",    {8'b0, bus.v_data}, 16'h0);
    rst = 1'b0;

    // Streaming decode table, one word per cycle
    for (int i = 0; i < 13; i++) begin
      put(1'b1, vecs[i].instr);
      tick();
      chk($sformatf("v%0d_valid", i), {15'b0, bus.out_valid}, 16'h1);
      chk($sformatf("v%0d_class", i), {8'b0, bus.op_class}, {8'b0, vecs[i].cls});
      chk($sformatf("v%0d_code", i),  {11'b0, bus.op_code}, {11'b0, vecs[i].code});
      chk($sformatf("v%0d_rd", i),    {12'b0, bus.rd}, {12'b0, vecs[i].rd});
      chk($sformatf("v%0d_rsa", i),   {12'b0, bus.rsa}, {12'b0, vecs[i].rsa});
      chk($sformatf("v%0d_rsb", i),   {12'b0, bus.rsb}, {12'b0, vecs[i].rsb});
      chk($sformatf("v%0d_vdata", i), {8'b0, bus.v_data}, {8'b0, vecs[i].v});
      chk($sformatf("v%0d_strb", i),  {13'b0, bus.load_en, bus.mul_en, bus.illegal},
                                      {13'b0, vecs[i].ld, vecs[i].mul, vecs[i].ill});
      chk($sformatf("v%0d_hold", i),  {15'b0, bus.hold_pc}, 16'h0);
    end
    put(1'b0, 16'h0000);
    tick();
    chk("idle_out_valid", {15'b0, bus.out_valid}, 16'h0);

    // Backpressure: hold, skid, refuse, then drain in order
    bus.out_ready = 1'b0;
    put(1'b1, 16'hA123);
    tick();
    chk("bp1_valid", {15'b0, bus.out_valid}, 16'h1);
    chk("bp1_rd", {12'b0, bus.rd}, 16'h1);
    chk("bp1_in_ready", {15'b0, bus.in_ready}, 16'h1);
    put(1'b1, 16'hC456);
    tick();
    chk("bp2_in_ready", {15'b0, bus.in_ready}, 16'h0);
    chk("bp2_rd_held", {12'b0, bus.rd}, 16'h1);
    chk("bp2_rsa_held", {12'b0, bus.rsa}, 16'h2);
    put(1'b1, 16'h4123);
    tick();
    chk("bp3_in_ready", {15'b0, bus.in_ready}, 16'h0);
    chk("bp3_rd_held", {12'b0, bus.rd}, 16'h1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp4_class", {8'b0, bus.op_class}, 16'h02);
    chk("bp4_mul_en", {15'b0, bus.mul_en}, 16'h1);
    chk("bp4_rd", {12'b0, bus.rd}, 16'h4);
    chk("bp4_in_ready", {15'b0, bus.in_ready}, 16'h1);
    tick();
    chk("bp5_class", {8'b0, bus.op_class}, 16'h08);
    chk("bp5_vdata", {8'b0, bus.v_data}, 16'h02);
    chk("bp5_mul_en", {15'b0, bus.mul_en}, 16'h0);
    put(1'b0, 16'h0000);
    tick();
    chk("bp6_valid", {15'b0, bus.out_valid}, 16'h0);

    // Squash window of two after RETURN
    put(1'b1, 16'h0110);
    tick();
    chk("sq0_class", {8'b0, bus.op_class}, 16'h20);
    chk("sq0_code", {11'b0, bus.op_code}, 16'h01);
    chk("sq0_valid", {15'b0, bus.out_valid}, 16'h1);
    put(1'b1, 16'hA123);
    tick();
    chk("sq1_valid", {15'b0, bus.out_valid}, 16'h1);
    chk("sq1_class", {8'b0, bus.op_class}, 16'h0);
    chk("sq1_rd", {12'b0, bus.rd}, 16'h0);
    chk("sq1_hold", {15'b0, bus.hold_pc}, 16'h1);
    chk("n0_class", {8'b0, bus0.op_class}, 16'h02);
    chk("n0_hold", {15'b0, bus0.hold_pc}, 16'h0);
    put(1'b1, 16'hA456);
    tick();
    chk("sq2_class", {8'b0, bus.op_class}, 16'h0);
    chk("sq2_hold", {15'b0, bus.hold_pc}, 16'h1);
    put(1'b1, 16'hA789);
    tick();
    chk("sq3_class", {8'b0, bus.op_class}, 16'h02);
    chk("sq3_rd", {12'b0, bus.rd}, 16'h7);
    chk("sq3_rsa", {12'b0, bus.rsa}, 16'h8);
    chk("sq3_hold", {15'b0, bus.hold_pc}, 16'h0);
    put(1'b0, 16'h0000);
    tick();
    chk("sq4_valid", {15'b0, bus.out_valid}, 16'h0);

    // Back-to-back RETURN: second one is a bubble and does not re-arm
    put(1'b1, 16'h0110);
    tick();
    tick();
    chk("bb1_class", {8'b0, bus.op_class}, 16'h0);
    chk("bb1_hold", {15'b0, bus.hold_pc}, 16'h1);
    put(1'b1, 16'hA123);
    tick();
    chk("bb2_class", {8'b0, bus.op_class}, 16'h0);
    tick();
    chk("bb3_class", {8'b0, bus.op_class}, 16'h02);
    chk("bb3_hold", {15'b0, bus.hold_pc}, 16'h0);

    // Flush mid-squash
    put(1'b1, 16'h0110);
    tick();
    bus.flush = 1'b1;
    put(1'b1, 16'hA456);
    tick();
    chk("fl1_valid", {15'b0, bus.out_valid}, 16'h0);
    chk("fl1_hold", {15'b0, bus.hold_pc}, 16'h0);
    chk("fl1_in_ready", {15'b0, bus.in_ready}, 16'h1);
    bus.flush = 1'b0;
    put(1'b1, 16'hA123);
    tick();
    chk("fl2_class", {8'b0, bus.op_class}, 16'h02);
    chk("fl2_rd", {12'b0, bus.rd}, 16'h1);
    chk("fl2_hold", {15'b0, bus.hold_pc}, 16'h0);

    // Reset with a full skid
    bus.out_ready = 1'b0;
    put(1'b1, 16'hA123);
    tick();
    put(1'b1, 16'hC456);
    tick();
    chk("rs0_in_ready", {15'b0, bus.in_ready}, 16'h0);
    rst = 1'b1;
    put(1'b0, 16'h0000);
    tick();
    chk("rs1_valid", {15'b0, bus.out_valid}, 16'h0);
    chk("rs1_in_ready", {15'b0, bus.in_ready}, 16'h1);
    chk("rs1_class", {8'b0, bus.op_class}, 16'h0);
    chk("rs1_rd", {12'b0, bus.rd}, 16'h0);
    chk("rs1_mul", {15'b0, bus.mul_en}, 16'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("rs2_valid", {15'b0, bus.out_valid}, 16'h0);
    tick();
    chk("rs3_valid", {15'b0, bus.out_valid}, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
